dm_cache_controller: RTL and testbench

- Sequencing controller for the direct-mapped read cache: 1024 lines × 4 × 32-bit words, 15-bit word address.
- Sits between the CPU request port, the cache tag/data array and main memory.
- Performs tag lookup, detects hit or miss, fetches whole 4-word lines from main memory on a miss, fills the array, and returns the requested word with a one-cycle ready pulse.
- One request outstanding at a time.

---
 rtl/dm_cache_controller.sv | 161 ++++++++++++++++
 tb/tb_dm_cache_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_controller.sv
// Sequencing controller for a direct-mapped, read-only cache: tag lookup, line fetch on miss,
// array fill and single-word return. Optional hit/miss counters under `CACHE_STATS_EN`.
module dm_cache_controller #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned TAG_W    = 3,
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned WORD_W   = 32,
  localparam int unsigned WORDS   = 1 << OFFSET_W,
  localparam int unsigned LINE_W  = WORD_W * WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_read,
  input  logic [ADDR_W-1:0]   cpu_address,
  output logic                cpu_ready,
  output logic [WORD_W-1:0]   cpu_data,
  output logic                busy,
  output logic [INDEX_W-1:0]  arr_index,
  input  logic [TAG_W-1:0]    arr_tag_rd,
  input  logic                arr_valid_rd,
  input  logic [LINE_W-1:0]   arr_line_rd,
  output logic                arr_write,
  output logic [TAG_W-1:0]    arr_tag_wr,
  output logic [LINE_W-1:0]   arr_line_wr,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_address,
  input  logic                mem_ready,
  input  logic [LINE_W-1:0]   mem_line
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StMemWait, StFill, StRespond} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_q, req_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                done_q, done_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_off;
  logic                hit;
  logic [WORD_W-1:0]   hit_word, fill_word;

  assign req_tag   = req_q[ADDR_W-1 -: TAG_W];
  assign req_index = req_q[OFFSET_W +: INDEX_W];
  assign req_off   = req_q[OFFSET_W-1:0];
  assign hit       = arr_valid_rd && (arr_tag_rd == req_tag);

  always_comb begin
    hit_word  = '0;
    fill_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (OFFSET_W'(k) == req_off) begin
        hit_word  = arr_line_rd[k*WORD_W +: WORD_W];
        fill_word = line_q[k*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    line_d  = line_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      StIdle: begin
        if (cpu_read) begin
          req_d   = cpu_address;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          data_d  = hit_word;
          state_d = StRespond;
        end else begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        // Line is captured on mem_ready; the request drops for one cycle before the fill.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = StFill;
        end else if (mem_ready) begin
          line_d = mem_line;
          done_d = 1'b1;
        end
      end
      StFill: begin
        data_d  = fill_word;
        state_d = StRespond;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      line_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      line_q  <= line_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    cpu_ready   = (state_q == StRespond);
    cpu_data    = data_q;
    mem_read    = (state_q == StMemWait) && !done_q;
    mem_address = {req_tag, req_index, {OFFSET_W{1'b0}}};
    arr_write   = (state_q == StFill);
    arr_tag_wr  = req_tag;
    arr_line_wr = line_q;
    // Idle follows the CPU so the tag read is ready by the lookup cycle.
    if (state_q == StIdle) begin
      arr_index = rst ? '0 : cpu_address[OFFSET_W +: INDEX_W];
    end else begin
      arr_index = req_index;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit && (hit_q != 16'hFFFF)) begin
        hit_q <= hit_q + 16'd1;
      end
      if (!hit && (miss_q != 16'hFFFF)) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dm_cache_controller.sv
// Scoreboard bench for dm_cache_controller: behavioural tag/data array and main memory,
// directed requests covering cold/conflict misses, hits, slow memory and reset mid-miss.
module tb_dm_cache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_read;
  logic [14:0]  cpu_address;
  logic         cpu_ready;
  logic [31:0]  cpu_data;
  logic         busy;
  logic [9:0]   arr_index;
  logic [2:0]   arr_tag_rd;
  logic         arr_valid_rd;
  logic [127:0] arr_line_rd;
  logic         arr_write;
  logic [2:0]   arr_tag_wr;
  logic [127:0] arr_line_wr;
  logic         mem_read;
  logic [14:0]  mem_address;
  logic         mem_ready;
  logic [127:0] mem_line;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dm_cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_read     (cpu_read),
    .cpu_address  (cpu_address),
    .cpu_ready    (cpu_ready),
    .cpu_data     (cpu_data),
    .busy         (busy),
    .arr_index    (arr_index),
    .arr_tag_rd   (arr_tag_rd),
    .arr_valid_rd (arr_valid_rd),
    .arr_line_rd  (arr_line_rd),
    .arr_write    (arr_write),
    .arr_tag_wr   (arr_tag_wr),
    .arr_line_wr  (arr_line_wr),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_ready    (mem_ready),
    .mem_line     (mem_line)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: line 1 (addresses 4..7) holds 0x00,0x11,0x22,0x33; elsewhere address-tagged.
  function automatic logic [31:0] memword(input logic [14:0] a);
    if (a[14:2] == 13'd1) return 32'h11 * {30'b0, a[1:0]};
    return {a, 15'h0, a[1:0]};
  endfunction

  function automatic logic [127:0] memline(input logic [14:0] a);
    logic [127:0] r;
    logic [14:0]  b;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      b = {a[14:2], 2'(k)};
      r[k*32 +: 32] = memword(b);
    end
    return r;
  endfunction

  // Behavioural array: one-cycle registered read, write on arr_write.
  logic [2:0]   tag_m   [1024];
  logic         valid_m [1024];
  logic [127:0] line_m  [1024];

  always @(posedge clk) begin
    arr_tag_rd   <= tag_m[arr_index];
    arr_valid_rd <= valid_m[arr_index];
    arr_line_rd  <= line_m[arr_index];
    if (arr_write) begin
      tag_m[arr_index]   <= arr_tag_wr;
      valid_m[arr_index] <= 1'b1;
      line_m[arr_index]  <= arr_line_wr;
    end
  end

  typedef struct {
    logic [14:0] addr;
    bit          miss;
  } exp_t;
  exp_t q[$];

  // Monitor: checks fills and responses against the queued expectations.
  int   writes = 0;
  bit   seen_mem = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      writes   = 0;
      seen_mem = 1'b0;
    end else begin
      if (mem_read) seen_mem = 1'b1;
      if (arr_write) begin
        writes++;
        if (q.size() == 0) begin
          check("unexpected arr_write", 1'b1, 1'b0);
        end else begin
          check("fill index", arr_index, q[0].addr[11:2]);
          check("fill tag", arr_tag_wr, q[0].addr[14:12]);
          check("fill line", arr_line_wr, memline(q[0].addr));
        end
      end
      if (cpu_ready) begin
        if (q.size() == 0) begin
          check("unexpected cpu_ready", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("cpu_data", cpu_data, memword(e.addr));
          check("miss path taken", seen_mem, e.miss);
          check("fill count", writes, e.miss ? 1 : 0);
        end
        writes   = 0;
        seen_mem = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [14:0] addr, input bit miss, input int delay);
    int n;
    bit ok;
    @(negedge clk);
    cpu_read    = 1'b1;
    cpu_address = addr;
    q.push_back('{addr: addr, miss: miss});
    @(negedge clk);
    check("busy in lookup", busy, 1'b1);
    if (miss) begin
      n = 0;
      while (!mem_read && n < 8) begin
        @(negedge clk);
        n++;
      end
      check("mem_read raised", mem_read, 1'b1);
      check("mem_address", mem_address, {addr[14:2], 2'b00});
      ok = 1'b1;
      repeat (delay) begin
        @(negedge clk);
        if (!mem_read) ok = 1'b0;
        cpu_address = 15'($urandom);
      end
      if (delay > 0) check("mem_read held", ok, 1'b1);
      mem_ready = 1'b1;
      mem_line  = memline(addr);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_line  = '0;
      check("mem_read dropped", mem_read, 1'b0);
    end
    n = 1;
    while (!cpu_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("ready latency", n, miss ? 3 : 2);
    cpu_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tag_m[i]   = '0;
      valid_m[i] = 1'b0;
      line_m[i]  = '0;
    end
    rst         = 1'b1;
    cpu_read    = 1'b0;
    cpu_address = 15'h0123;
    mem_ready   = 1'b0;
    mem_line    = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset cpu_ready", cpu_ready, 1'b0);
    check("reset mem_read", mem_read, 1'b0);
    check("reset arr_write", arr_write, 1'b0);
    check("reset cpu_data", cpu_data, 32'h0);
    check("reset mem_address", mem_address, 15'h0);
    check("reset arr_index", arr_index, 10'h0);
    check("reset arr_line_wr", arr_line_wr, 128'h0);
    rst = 1'b0;
    cpu_address = 15'h0;

    do_req(15'h0005, 1'b1, 0);   // cold miss -> 0x11
    do_req(15'h0006, 1'b0, 0);   // hit -> 0x22
    do_req(15'h1004, 1'b1, 1);   // conflict miss, tag 1
    do_req(15'h0004, 1'b1, 0);   // evicted, misses again
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("hit_count", hit_count, 16'd1);
    check("miss_count", miss_count, 16'd3);
`endif
    do_req(15'h0007, 1'b0, 0);   // hit -> 0x33

    // Reset during the memory wait aborts the miss.
    @(negedge clk);
    cpu_read    = 1'b1;
    cpu_address = 15'h0008;
    repeat (2) @(negedge clk);
    check("mem_read before abort", mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check("abort mem_read", mem_read, 1'b0);
    check("abort busy", busy, 1'b0);
    cpu_read = 1'b0;
`ifdef CACHE_STATS_EN
    check("hit_count after rst", hit_count, 16'd0);
    check("miss_count after rst", miss_count, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    do_req(15'h0008, 1'b1, 2);   // still a miss after the abort
    do_req(15'h0107, 1'b1, 20);  // slow memory, address wiggles while waiting
    do_req(15'h0105, 1'b0, 0);   // hit in the slow-filled line

    repeat (4) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
